exe_unit_pipe: RTL and testbench

- Parametrised, handshaked successor to the registered 4-op execution unit.
- Adds an 8-op set, ADD, a multi-cycle shift-add multiplier and a rotate, on a 2-stage valid/ready pipeline with backpressure.
- Sits between the operand/decode front end and the writeback path; the status encoding and the parity/single-zero flag semantics are unchanged.

---
 rtl/exe_unit_pipe.sv | 191 +++++++++++++++++++
 tb/tb_exe_unit_pipe.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exe_unit_pipe.sv
// Two-stage valid/ready execution unit: 8-op ALU with a multi-cycle shift-add
// multiplier in stage 1 and a registered result/status stage 2.

`ifndef OVF_BIT
`define OVF_BIT 0
`endif
`ifndef ERROR_BIT
`define ERROR_BIT 1
`endif
`ifndef EVEN_BIT
`define EVEN_BIT 2
`endif
`ifndef SINGLE_BIT
`define SINGLE_BIT 3
`endif

module exe_unit_pipe #(
  parameter int unsigned BITS  = 8,
  parameter int unsigned CNT_W = $clog2(BITS) + 1
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [BITS-1:0] in_a,
  input  logic [BITS-1:0] in_b,
  input  logic [2:0]      i_op,
  input  logic            i_valid,
  output logic            o_ready,
  output logic [BITS-1:0] o_out,
  output logic [3:0]      o_status,
  output logic            o_valid,
  input  logic            i_ready,
  output logic            o_busy
);

  localparam int unsigned     W2      = 2 * BITS;
  localparam logic [BITS-1:0] BitsL   = BITS'(BITS);
  localparam logic [CNT_W-1:0] CntLast = CNT_W'(BITS - 1);

  localparam logic [2:0] OpSub  = 3'b000;
  localparam logic [2:0] OpCmp  = 3'b001;
  localparam logic [2:0] OpShl  = 3'b010;
  localparam logic [2:0] OpTgl  = 3'b011;
  localparam logic [2:0] OpAdd  = 3'b100;
  localparam logic [2:0] OpMul  = 3'b101;
  localparam logic [2:0] OpRotl = 3'b110;

  typedef enum logic [1:0] {StIdle, StIter, StDone} mul_st_e;

  logic            s1_valid_q;
  logic [BITS-1:0] s1_a_q, s1_b_q;
  logic [2:0]      s1_op_q;
  logic            s2_valid_q;
  logic [BITS-1:0] s2_out_q;
  logic [3:0]      s2_status_q;

  mul_st_e          mst_q;
  logic [CNT_W-1:0] cnt_q;
  logic [W2-1:0]    acc_q, mc_q;
  logic [BITS-1:0]  mp_q;

  logic            s1_done, s1_adv, in_fire, b_big;
  logic [BITS-1:0] res, rot_amt;
  logic            ovf, err;
  logic [W2-1:0]   shl_w;
  logic [BITS:0]   sum_w, diff_w;
  logic [CNT_W-1:0] zeros;
  logic [3:0]      status_w;

  assign s1_done = (s1_op_q != OpMul) || (mst_q == StDone);
  assign s1_adv  = s1_valid_q && s1_done && (!s2_valid_q || i_ready);
  assign o_ready = i_rst && (!s1_valid_q || s1_adv);
  assign in_fire = i_valid && o_ready;

  assign b_big   = s1_b_q >= BitsL;
  assign rot_amt = s1_b_q % BitsL;
  assign shl_w   = {{BITS{1'b0}}, s1_a_q} << s1_b_q;
  assign sum_w   = {1'b0, s1_a_q} + {1'b0, s1_b_q};
  assign diff_w  = {1'b0, s1_a_q} - {1'b0, s1_b_q};

  always_comb begin
    res = '0;
    ovf = 1'b0;
    err = 1'b0;
    case (s1_op_q)
      OpSub: begin
        res = diff_w[BITS-1:0];
        ovf = diff_w[BITS];
      end
      OpCmp: res = {{(BITS-1){1'b0}}, s1_a_q > s1_b_q};
      OpShl: begin
        if (b_big) begin
          err = 1'b1;
        end else begin
          res = shl_w[BITS-1:0];
          ovf = |shl_w[W2-1:BITS];
        end
      end
      OpTgl: begin
        if (b_big) err = 1'b1;
        else       res = s1_a_q ^ (BITS'(1) << s1_b_q);
      end
      OpAdd: begin
        res = sum_w[BITS-1:0];
        ovf = sum_w[BITS];
      end
      OpMul: begin
        res = acc_q[BITS-1:0];
        ovf = |acc_q[W2-1:BITS];
      end
      // A zero rotate shifts right by BITS, which yields 0 and leaves a intact.
      OpRotl: res = (s1_a_q << rot_amt) | (s1_a_q >> (BitsL - rot_amt));
      default: err = 1'b1;
    endcase
  end

  always_comb begin
    zeros = '0;
    for (int i = 0; i < BITS; i++) begin
      zeros = zeros + CNT_W'(~res[i]);
    end
    status_w              = '0;
    status_w[`OVF_BIT]    = ovf;
    status_w[`ERROR_BIT]  = err;
    status_w[`EVEN_BIT]   = ~zeros[0];
    status_w[`SINGLE_BIT] = (zeros == CNT_W'(1));
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      s1_valid_q  <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_op_q     <= '0;
      s2_valid_q  <= 1'b0;
      s2_out_q    <= '0;
      s2_status_q <= '0;
      mst_q       <= StIdle;
      cnt_q       <= '0;
      acc_q       <= '0;
      mc_q        <= '0;
      mp_q        <= '0;
    end else begin
      if (s1_adv) begin
        s2_valid_q  <= 1'b1;
        s2_out_q    <= res;
        s2_status_q <= status_w;
      end else if (s2_valid_q && i_ready) begin
        s2_valid_q <= 1'b0;
      end

      if (in_fire) begin
        s1_valid_q <= 1'b1;
        s1_a_q     <= in_a;
        s1_b_q     <= in_b;
        s1_op_q    <= i_op;
      end else if (s1_adv) begin
        s1_valid_q <= 1'b0;
      end

      // A new MUL starts iterating from the edge that captures it into S1.
      if (in_fire && (i_op == OpMul)) begin
        mst_q <= StIter;
        cnt_q <= '0;
        acc_q <= '0;
        mc_q  <= {{BITS{1'b0}}, in_a};
        mp_q  <= in_b;
      end else begin
        case (mst_q)
          StIter: begin
            if (mp_q[0]) acc_q <= acc_q + mc_q;
            mc_q  <= mc_q << 1;
            mp_q  <= mp_q >> 1;
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == CntLast) begin
              mst_q <= StDone;
              cnt_q <= '0;
            end
          end
          StDone: if (s1_adv) mst_q <= StIdle;
          default: ;
        endcase
      end
    end
  end

  assign o_out    = s2_out_q;
  assign o_status = s2_status_q;
  assign o_valid  = s2_valid_q;
  assign o_busy   = (mst_q == StIter);

endmodule

// File: tb/tb_exe_unit_pipe.sv
// Scoreboard bench for exe_unit_pipe: expected results are queued at accept
// and compared when the unit hands them downstream.

`ifndef OVF_BIT
`define OVF_BIT 0
`endif
`ifndef ERROR_BIT
`define ERROR_BIT 1
`endif
`ifndef EVEN_BIT
`define EVEN_BIT 2
`endif
`ifndef SINGLE_BIT
`define SINGLE_BIT 3
`endif

module tb_exe_unit_pipe;

  localparam logic [2:0] OpSub  = 3'b000;
  localparam logic [2:0] OpCmp  = 3'b001;
  localparam logic [2:0] OpShl  = 3'b010;
  localparam logic [2:0] OpTgl  = 3'b011;
  localparam logic [2:0] OpAdd  = 3'b100;
  localparam logic [2:0] OpMul  = 3'b101;
  localparam logic [2:0] OpRotl = 3'b110;
  localparam logic [2:0] OpRsv  = 3'b111;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] in_a = '0, in_b = '0;
  logic [2:0] i_op = '0;
  logic       i_valid = 1'b0;
  logic       i_ready = 1'b1;
  logic       o_ready, o_valid, o_busy;
  logic [7:0] o_out;
  logic [3:0] o_status;

  typedef struct packed {
    logic [7:0] out;
    logic [3:0] st;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  exe_unit_pipe #(.BITS(8)) dut (
    .i_clk    (clk),
    .i_rst    (rst_n),
    .in_a     (in_a),
    .in_b     (in_b),
    .i_op     (i_op),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .o_out    (o_out),
    .o_status (o_status),
    .o_valid  (o_valid),
    .i_ready  (i_ready),
    .o_busy   (o_busy)
  );

  function automatic logic [3:0] st(input logic ovf, input logic err, input logic even,
                                    input logic single);
    logic [3:0] s;
    s              = '0;
    s[`OVF_BIT]    = ovf;
    s[`ERROR_BIT]  = err;
    s[`EVEN_BIT]   = even;
    s[`SINGLE_BIT] = single;
    return s;
  endfunction

  // Results leave the unit at the posedge following a negedge with valid && ready.
  always @(negedge clk) begin
    if (rst_n && o_valid && i_ready) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_result: got out=%h status=%b, required no result",
                 o_out, o_status);
      end else begin
        mon_e = sb_q.pop_front();
        if ({o_out, o_status} !== {mon_e.out, mon_e.st}) begin
          errors++;
          $display("FAIL result: got out=%h status=%b, required out=%h status=%b",
                   o_out, o_status, mon_e.out, mon_e.st);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                       input logic [7:0] eo, input logic [3:0] es, input bit push);
    bit   got;
    exp_t e;
    in_a    = a;
    in_b    = b;
    i_op    = op;
    i_valid = 1'b1;
    got     = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (o_ready) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout: got o_ready=0 for 40 cycles, required 1 (op=%b)", op);
    end else begin
      @(posedge clk);
      e.out = eo;
      e.st  = es;
      if (push) sb_q.push_back(e);
    end
    #1 i_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int n = 0; n < 60 && sb_q.size() != 0; n++) @(posedge clk);
    #1;
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending, required 0", sb_q.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b, required 0", o_valid); end
    checks++; if (o_out !== 8'h00) begin errors++; $display("FAIL rst_out: got %h, required 00", o_out); end
    checks++; if (o_status !== 4'h0) begin errors++; $display("FAIL rst_status: got %b, required 0000", o_status); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b, required 0", o_busy); end
    checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b, required 0", o_ready); end
    rst_n = 1'b1;
    #1;
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL ready_after_rst: got %b, required 1", o_ready); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_sub();
    issue(8'h05, 8'h07, OpSub, 8'hFE, st(1, 0, 0, 1), 1'b1);
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL sub_latency_early: got o_valid=%b, required 0", o_valid); end
    @(posedge clk);
    #1;
    checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL sub_latency: got o_valid=%b, required 1", o_valid); end
    wait_drain();
  endtask

  task automatic test_shift_rot();
    issue(8'h81, 8'h01, OpShl, 8'h02, st(1, 0, 0, 0), 1'b1);
    issue(8'h81, 8'h08, OpShl, 8'h00, st(0, 1, 1, 0), 1'b1);
    issue(8'h81, 8'h09, OpRotl, 8'h03, st(0, 0, 1, 0), 1'b1);
    wait_drain();
  endtask

  task automatic test_tgl_reserved();
    issue(8'hFF, 8'h03, OpTgl, 8'hF7, st(0, 0, 0, 1), 1'b1);
    issue(8'hFF, 8'h08, OpTgl, 8'h00, st(0, 1, 1, 0), 1'b1);
    issue(8'h12, 8'h34, OpRsv, 8'h00, st(0, 1, 1, 0), 1'b1);
    wait_drain();
  endtask

  task automatic test_back_to_back();
    time t0;
    t0 = $time;
    issue(8'hFF, 8'h02, OpAdd, 8'h01, st(1, 0, 0, 0), 1'b1);
    issue(8'h05, 8'h03, OpCmp, 8'h01, st(0, 0, 0, 0), 1'b1);
    issue(8'h03, 8'h05, OpCmp, 8'h00, st(0, 0, 1, 0), 1'b1);
    issue(8'h09, 8'h03, OpSub, 8'h06, st(0, 0, 1, 0), 1'b1);
    checks++;
    if (($time - t0) != 40) begin
      errors++;
      $display("FAIL throughput: got %0t for 4 ops, required 40", $time - t0);
    end
    wait_drain();
  endtask

  task automatic test_mul();
    int  bcnt, vedge;
    bit  rdy_bad;
    issue(8'h0F, 8'h03, OpMul, 8'h2D, st(0, 0, 1, 0), 1'b1);
    bcnt    = 0;
    vedge   = 0;
    rdy_bad = 1'b0;
    // Iteration i observes the state just after edge k+i-1.
    for (int i = 1; i <= 12; i++) begin
      if (o_busy) bcnt++;
      if (o_busy && o_ready) rdy_bad = 1'b1;
      if (o_valid && vedge == 0) vedge = i;
      @(posedge clk);
      #1;
    end
    checks++; if (bcnt != 8) begin errors++; $display("FAIL mul_busy_cycles: got %0d, required 8", bcnt); end
    checks++; if (vedge != 10) begin errors++; $display("FAIL mul_latency: got edge k+%0d, required k+9", vedge - 1); end
    checks++; if (rdy_bad) begin errors++; $display("FAIL mul_ready_in_iter: got o_ready=1 while busy, required 0"); end
    issue(8'h10, 8'h11, OpMul, 8'h10, st(1, 0, 0, 0), 1'b1);
    wait_drain();
  endtask

  task automatic test_backpressure();
    exp_t e;
    i_ready = 1'b0;
    in_a = 8'h09; in_b = 8'h03; i_op = OpSub; i_valid = 1'b1;
    @(negedge clk);
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL bp_accept1: got o_ready=%b, required 1", o_ready); end
    @(posedge clk);
    e.out = 8'h06; e.st = st(0, 0, 1, 0); sb_q.push_back(e);
    #1 in_a = 8'hFF; in_b = 8'h02; i_op = OpAdd;
    @(negedge clk);
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL bp_accept2: got o_ready=%b, required 1", o_ready); end
    @(posedge clk);
    e.out = 8'h01; e.st = st(1, 0, 0, 0); sb_q.push_back(e);
    #1 in_a = 8'h05; in_b = 8'h03; i_op = OpCmp;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_low: got %b, required 0", o_ready); end
      checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL bp_valid_held: got %b, required 1", o_valid); end
      checks++;
      if ({o_out, o_status} !== {8'h06, st(0, 0, 1, 0)}) begin
        errors++;
        $display("FAIL bp_out_held: got out=%h status=%b, required out=06 status=%b",
                 o_out, o_status, st(0, 0, 1, 0));
      end
    end
    @(posedge clk);
    #1 i_ready = 1'b1;
    @(negedge clk);
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL bp_release: got o_ready=%b, required 1", o_ready); end
    @(posedge clk);
    e.out = 8'h01; e.st = st(0, 0, 0, 0); sb_q.push_back(e);
    #1 i_valid = 1'b0;
    wait_drain();
  endtask

  task automatic test_reset_mul();
    issue(8'h0F, 8'h03, OpMul, 8'h2D, st(0, 0, 1, 0), 1'b0);
    repeat (3) @(posedge clk);
    #1;
    checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL busy_before_abort: got %b, required 1", o_busy); end
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL abort_valid: got %b, required 0", o_valid); end
    checks++; if (o_out !== 8'h00) begin errors++; $display("FAIL abort_out: got %h, required 00", o_out); end
    checks++; if (o_status !== 4'h0) begin errors++; $display("FAIL abort_status: got %b, required 0000", o_status); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b, required 0", o_busy); end
    checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL abort_ready: got %b, required 0", o_ready); end
    rst_n = 1'b1;
    repeat (14) @(posedge clk);
    #1;
    issue(8'h7F, 8'h01, OpAdd, 8'h80, st(0, 0, 0, 0), 1'b1);
    wait_drain();
  endtask

  initial begin
    test_reset();
    test_sub();
    test_shift_rot();
    test_tgl_reserved();
    test_back_to_back();
    test_mul();
    test_backpressure();
    test_reset_mul();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_empty: got %0d pending, required 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
